// File: rtl/mini_spi_pkg.sv
// Shared types and constants for the Mini_SPI datapath.
// Holds the shift-engine state encoding and the bit-order selector values.
package mini_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shifter_state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_shifter.sv
// Parametrised serial/parallel shift engine with parallel load, selectable bit
// order, full-duplex serial output and a frame bit counter with busy/done.
module spi_shifter
  import mini_spi_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             lsbFirst,
  input  logic             shift,
  input  logic             serialIn,
  output logic             serialOut,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bitCount,
  output logic             busy,
  output logic             done
);

  shifter_state_e   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] shifted_msb;
  logic [WIDTH-1:0] shifted_lsb;
  logic [CNT_W-1:0] cnt_inc;

  // A one-bit register has no neighbouring bits to move, so both orders
  // collapse to a plain capture of the serial input.
  if (WIDTH == 1) begin : g_w1
    assign shifted_msb = serialIn;
    assign shifted_lsb = serialIn;
  end else begin : g_wn
    assign shifted_msb = {shreg_q[WIDTH-2:0], serialIn};
    assign shifted_lsb = {serialIn, shreg_q[WIDTH-1:1]};
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (load) begin
          shreg_d = parallelIn;
          dir_d   = lsbFirst;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (load) begin
          shreg_d = parallelIn;
          dir_d   = lsbFirst;
          cnt_d   = '0;
        end else if (shift) begin
          shreg_d = (dir_q == LSB_FIRST) ? shifted_lsb : shifted_msb;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(WIDTH)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign serialOut = (dir_q == LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
  assign q         = shreg_q;
  assign bitCount  = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
